// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson-code receiver tile.
package johnson_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'b00,
        LOCKED  = 2'b01,
        ERROR   = 2'b10
    } state_t;

    localparam int unsigned UIO_LOCKED_BIT = 2;
    localparam int unsigned UIO_STEP_BIT   = 3;
    localparam int unsigned UIO_ERR_BIT    = 4;
    localparam int unsigned UIO_STICKY_BIT = 5;
    localparam int unsigned UIO_STATE_LSB  = 6;

    localparam logic [7:0] UIO_OE = 8'b1111_1100;

    // Successor of idx in a 2n-state Johnson sequence (wraps 2n-1 -> 0).
    function automatic logic [3:0] next_idx(input logic [3:0] idx, input int unsigned n);
        if (32'(idx) == (2 * n) - 1) begin
            return 4'd0;
        end
        return idx + 4'd1;
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code to binary index decoder; flags non-Johnson patterns.
module johnson_code_decode #(
    parameter int unsigned N = 8,
    localparam int unsigned IW = $clog2(2 * N)
) (
    input  logic [N-1:0]  code,
    output logic          valid,
    output logic [IW-1:0] index
);

    // Thermometer pattern with the low k bits set.
    function automatic logic [N-1:0] thermo(input int unsigned k);
        logic [N-1:0] t;
        for (int unsigned b = 0; b < N; b++) begin
            t[b] = (b < k);
        end
        return t;
    endfunction

    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int unsigned k = 0; k <= N; k++) begin
            if (code == thermo(k)) begin
                valid = 1'b1;
                index = IW'(k);
            end
        end
        // Falling half of the sequence: low k bits cleared, rest set.
        for (int unsigned k = 1; k < N; k++) begin
            if (code == ~thermo(k)) begin
                valid = 1'b1;
                index = IW'(N + k);
            end
        end
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: synchronizes ui_in, decodes, locks onto the +1 stream
// and counts good steps and errors.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int unsigned N           = 8,
    parameter int unsigned LOCK_COUNT  = 3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned IW = $clog2(2 * N);
    localparam int unsigned LW = $clog2(LOCK_COUNT + 1);

    logic [N-1:0]  sync_q [SYNC_STAGES];
    logic          dec_valid;
    logic [IW-1:0] dec_idx;

    state_t        state_q, state_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0]    step_q, step_d;
    logic [3:0]    err_q, err_d;
    logic          sticky_q, sticky_d;
    logic          step_pulse_q, step_pulse_d;
    logic          err_pulse_q, err_pulse_d;

    logic          is_hold, is_fwd, inc_step, inc_err;
    logic          unused_bits;

    assign unused_bits = ^{uio_in[7:2], ui_in};

    // Synchronizer runs regardless of ena.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= ui_in[N-1:0];
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    johnson_code_decode #(.N(N)) u_decode (
        .code  (sync_q[SYNC_STAGES-1]),
        .valid (dec_valid),
        .index (dec_idx)
    );

    assign is_hold = (dec_idx == idx_q);
    assign is_fwd  = (dec_idx == IW'(next_idx(4'(idx_q), N)));

    // Next-state for FSM, lock counter, index and statistics.
    always_comb begin
        state_d      = state_q;
        lock_d       = lock_q;
        idx_d        = idx_q;
        step_d       = step_q;
        err_d        = err_q;
        sticky_d     = sticky_q;
        step_pulse_d = 1'b0;
        err_pulse_d  = 1'b0;
        inc_step     = 1'b0;
        inc_err      = 1'b0;

        if (ena) begin
            case (state_q)
                ACQUIRE: begin
                    if (!dec_valid) begin
                        state_d = ERROR;
                    end else if (is_fwd) begin
                        if (lock_q == LW'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                            lock_d  = LW'(LOCK_COUNT);
                        end else begin
                            lock_d = lock_q + LW'(1);
                        end
                    end else if (!is_hold) begin
                        lock_d = LW'(1);
                    end
                end
                LOCKED: begin
                    if (!dec_valid) begin
                        err_pulse_d = 1'b1;
                        inc_err     = 1'b1;
                        state_d     = ERROR;
                    end else if (is_fwd) begin
                        step_pulse_d = 1'b1;
                        inc_step     = 1'b1;
                    end else if (!is_hold) begin
                        err_pulse_d = 1'b1;
                        inc_err     = 1'b1;
                        state_d     = ACQUIRE;
                        lock_d      = '0;
                    end
                end
                ERROR: begin
                    if (dec_valid) begin
                        state_d = ACQUIRE;
                        lock_d  = LW'(1);
                    end
                end
                default: begin
                    state_d = ACQUIRE;
                    lock_d  = '0;
                end
            endcase

            if (dec_valid) begin
                idx_d = dec_idx;
            end

            // Clear beats any increment in the same cycle.
            if (uio_in[0]) begin
                step_d   = 8'd0;
                err_d    = 4'd0;
                sticky_d = 1'b0;
            end else begin
                if (inc_step) begin
                    step_d = step_q + 8'd1;
                end
                if (inc_err) begin
                    if (err_q != 4'hF) begin
                        err_d = err_q + 4'd1;
                    end
                    sticky_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACQUIRE;
            lock_q       <= '0;
            idx_q        <= '0;
            step_q       <= 8'd0;
            err_q        <= 4'd0;
            sticky_q     <= 1'b0;
            step_pulse_q <= 1'b0;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            idx_q        <= idx_d;
            step_q       <= step_d;
            err_q        <= err_d;
            sticky_q     <= sticky_d;
            step_pulse_q <= step_pulse_d;
            err_pulse_q  <= err_pulse_d;
        end
    end

    assign uo_out = uio_in[1] ? step_q : {err_q, 4'(idx_q)};

    always_comb begin
        uio_out                         = 8'd0;
        uio_out[UIO_LOCKED_BIT]         = (state_q == LOCKED);
        uio_out[UIO_STEP_BIT]           = step_pulse_q;
        uio_out[UIO_ERR_BIT]            = err_pulse_q;
        uio_out[UIO_STICKY_BIT]         = sticky_q;
        uio_out[UIO_STATE_LSB +: 2]     = state_q;
    end

    assign uio_oe = UIO_OE;

endmodule

// File: tb/tb_johnson_decoder.sv
// Randomized bench for johnson_decoder against a spec-level reference model.
module tb_johnson_decoder;

    localparam int NN   = 8;
    localparam int NS   = 2 * NN;
    localparam int SYNC = 2;
    localparam int LOCK = 3;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks;
    int n_errors;

    // Reference model state (0=acquire, 1=locked, 2=error).
    logic [7:0] m_pipe [SYNC];
    int m_state, m_lock, m_idx, m_step, m_err;
    bit m_sticky, m_sp, m_ep;
    int cur;

    johnson_decoder #(.N(NN), .LOCK_COUNT(LOCK), .SYNC_STAGES(SYNC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] jcode(input int s);
        logic [7:0] full;
        full = 8'((1 << NN) - 1);
        if (s <= NN) return 8'((1 << s) - 1);
        return full ^ 8'((1 << (s - NN)) - 1);
    endfunction

    function automatic int decode(input logic [7:0] code);
        for (int s = 0; s < NS; s++) begin
            if (jcode(s) == code) return s;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SYNC; i++) m_pipe[i] = 8'd0;
        m_state = 0; m_lock = 0; m_idx = 0; m_step = 0; m_err = 0;
        m_sticky = 0; m_sp = 0; m_ep = 0;
    endtask

    // Advance the model by one clock with the inputs currently applied.
    task automatic model_step(input logic [7:0] code_in, input bit en, input bit clr);
        logic [7:0] code;
        int k;
        bit inc_s, inc_e;
        code = m_pipe[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
        m_pipe[0] = code_in;
        m_sp = 0; m_ep = 0;
        if (!en) return;
        k = decode(code);
        inc_s = 0; inc_e = 0;
        case (m_state)
            0: begin
                if (k < 0) m_state = 2;
                else if (k == (m_idx + 1) % NS) begin
                    m_lock++;
                    if (m_lock >= LOCK) m_state = 1;
                end else if (k != m_idx) m_lock = 1;
            end
            1: begin
                if (k < 0) begin
                    m_ep = 1; inc_e = 1; m_state = 2;
                end else if (k == (m_idx + 1) % NS) begin
                    m_sp = 1; inc_s = 1;
                end else if (k != m_idx) begin
                    m_ep = 1; inc_e = 1; m_state = 0; m_lock = 0;
                end
            end
            default: begin
                if (k >= 0) begin
                    m_state = 0; m_lock = 1;
                end
            end
        endcase
        if (k >= 0) m_idx = k;
        if (clr) begin
            m_step = 0; m_err = 0; m_sticky = 0;
        end else begin
            if (inc_s) m_step = (m_step + 1) % 256;
            if (inc_e) begin
                if (m_err < 15) m_err++;
                m_sticky = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] e;
        e = 8'd0;
        e[7:6] = 2'(m_state);
        e[5] = m_sticky;
        e[4] = m_ep;
        e[3] = m_sp;
        e[2] = (m_state == 1);
        uio_in[1] = 1'b0;
        #1;
        chk({tag, "_uo_m0"}, uo_out, {4'(m_err), 4'(m_idx)});
        uio_in[1] = 1'b1;
        #1;
        chk({tag, "_uo_m1"}, uo_out, 8'(m_step));
        chk({tag, "_uio"}, uio_out, e);
        chk({tag, "_oe"}, uio_oe, 8'hFC);
    endtask

    task automatic cyc(input logic [7:0] code, input bit en, input bit clr, input string tag);
        ui_in = code;
        ena = en;
        uio_in[0] = clr;
        uio_in[7:2] = 6'($urandom);
        model_step(code, en, clr);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic drive(input logic [7:0] code, input int n, input bit en, input bit clr, input string tag);
        for (int i = 0; i < n; i++) cyc(code, en, clr, tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cur = 0;
    endtask

    // From an acquire/error state with the model at index cur, walk three +1 steps.
    task automatic relock();
        for (int i = 0; i < LOCK; i++) begin
            cur = (cur + 1) % NS;
            drive(jcode(cur), 4, 1'b1, 1'b0, "relock");
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        ena = 1'b1;
        ui_in = 8'd0;
        uio_in = 8'd0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Acquire: 0x00,0x01,0x03,0x07.
        for (int s = 0; s < 4; s++) drive(jcode(s), 4, 1'b1, 1'b0, "acq");
        cur = 3;
        chk("locked_after_acq", {7'd0, uio_out[2]}, 8'd1);

        // Two full cycles including the 0x80 -> 0x00 wrap.
        for (int i = 0; i < 2 * NS; i++) begin
            cur = (cur + 1) % NS;
            drive(jcode(cur), 4, 1'b1, 1'b0, "walk");
        end
        uio_in[1] = 1'b1;
        #1;
        chk("step_count_32", uo_out, 8'd32);

        // Skip 3 -> 6.
        drive(8'h3F, 4, 1'b1, 1'b0, "skip");
        cur = 6;
        uio_in[1] = 1'b0;
        #1;
        chk("err_after_skip", {4'd0, uo_out[7:4]}, 8'd1);
        chk("state_after_skip", {6'd0, uio_out[7:6]}, 8'd0);

        // Relock, then an invalid code, then recover through 4..7.
        relock();
        drive(8'h05, 4, 1'b1, 1'b0, "invalid");
        chk("state_error", {6'd0, uio_out[7:6]}, 8'd2);
        drive(8'h0F, 4, 1'b1, 1'b0, "recover");
        drive(8'h1F, 4, 1'b1, 1'b0, "recover");
        drive(8'h3F, 4, 1'b1, 1'b0, "recover");
        drive(8'h7F, 4, 1'b1, 1'b0, "recover");
        cur = 7;
        chk("relocked", {7'd0, uio_out[2]}, 8'd1);

        // Saturate the error counter.
        for (int e = 0; e < 20; e++) begin
            drive(8'h05, 4, 1'b1, 1'b0, "sat_err");
            relock();
        end
        uio_in[1] = 1'b0;
        #1;
        chk("err_saturated", {4'd0, uo_out[7:4]}, 8'd15);

        // Clear coincident with an error.
        drive(8'h05, 4, 1'b1, 1'b1, "clr_err");
        chk("err_cleared", {4'd0, uo_out[7:4]}, 8'd0);
        chk("sticky_cleared", {7'd0, uio_out[5]}, 8'd0);
        relock();

        // Frozen while ena=0, then realign the input before re-enabling.
        for (int i = 1; i <= 5; i++) drive(jcode((cur + i) % NS), 3, 1'b0, 1'b1, "frozen");
        drive(jcode(cur), 4, 1'b1, 1'b0, "thaw");

        // Reset in the middle of LOCKED.
        drive(jcode((cur + 1) % NS), 4, 1'b1, 1'b0, "pre_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_uio", uio_out, 8'd0);
        uio_in[1] = 1'b0;
        #1;
        chk("rst_async_uo", uo_out, 8'd0);
        @(negedge clk);
        do_reset();

        // Randomized traffic.
        for (int it = 0; it < 2500; it++) begin
            int r, n;
            logic [7:0] code;
            bit en, clr;
            r = int'($urandom_range(0, 99));
            n = int'($urandom_range(1, 4));
            en = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 31) == 0);
            if (r < 55) begin
                cur = (cur + 1) % NS;
                code = jcode(cur);
            end else if (r < 70) begin
                code = jcode(cur);
            end else if (r < 82) begin
                cur = (cur + int'($urandom_range(2, NS - 1))) % NS;
                code = jcode(cur);
            end else if (r < 97) begin
                code = 8'($urandom);
                for (int t = 0; t < 64 && decode(code) >= 0; t++) code = 8'($urandom);
                if (decode(code) >= 0) code = 8'h05;
            end else begin
                code = jcode(cur);
                do_reset();
                code = 8'd0;
            end
            drive(code, n, en, clr, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/johnson_decoder.md
Name: johnson_decoder

Overview:
- TinyTapeout-tile receiver for the 8-bit Johnson counter output: samples an external Johnson code on ui_in and decodes it to a binary index.
- Checks every transition against the legal +1 sequence and locks onto the stream.
- Counts good steps and errors, reporting them on uo_out and uio_out.
- Sits on the far end of a board or loopback connection from the johnson tile; also used to verify that tile on silicon.

Parameters:
- N, 8, Johnson code width (2..8); uses ui_in[N-1:0], ignores the upper bits; 2N states; IW = $clog2(2N).
- LOCK_COUNT, 3, consecutive legal observations needed in ACQUIRE to reach LOCKED.
- SYNC_STAGES, 2, flip-flop synchronizer depth on ui_in (≥2).

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  tile enable; 0 freezes FSM and counters.
- ui_in  in  8  Johnson code input, asynchronous to clk.
- uio_in  in  8  [0] clear (sync, active-high); [1] display mode; others ignored.
- uo_out  out  8  mode0: {err_count[3:0], index[3:0]}; mode1: step_count[7:0].
- uio_out  out  8  [1:0]=0; [2] locked; [3] step_pulse; [4] err_pulse; [5] err_sticky; [7:6] state.
- uio_oe  out  8  constant 8'b1111_1100.

Behaviour:
- Reset (async, rst_n=0): synchronizer=0, index=0, prev=0, state=ACQUIRE, lock_cnt=0, step_count=0, err_count=0, err_sticky=0, pulses=0. Thus uo_out=0 and uio_out=0 (state encoding ACQUIRE=2'b00).
- Reset asserted mid-operation clears everything immediately; no partial state survives.
- Synchronizer: SYNC_STAGES flops on ui_in[N-1:0], always clocked, independent of ena.
- Decode (combinational on the synchronizer output):
  - valid code k in 0..N: low k bits are 1, rest 0 → index k.
  - valid code k in 1..N-1: low k bits are 0, rest 1 → index N+k.
  - Any other pattern is invalid.
- Result is registered; index updates SYNC_STAGES+1 cycles after a stable ui_in change.
- index holds its last valid value on an invalid code.
- Step test: legal = (idx == prev) or (idx == (prev+1) mod 2N); 2N-1 → 0 wraps as a legal step.
- FSM (evaluated each cycle with ena=1; encoding ACQUIRE=00, LOCKED=01, ERROR=10):
  - ACQUIRE:
    - invalid code → ERROR.
    - valid and legal step → lock_cnt++, reaching LOCK_COUNT → LOCKED.
    - valid but illegal → lock_cnt=1.
    - hold cycles do not increment lock_cnt.
    - No counting and no err_pulse in ACQUIRE.
  - LOCKED:
    - hold → nothing.
    - +1 step → step_pulse=1, step_count++ (8-bit wrap).
    - valid skip/backward → err_pulse, err_count++, err_sticky=1, → ACQUIRE with lock_cnt=0.
    - invalid code → err_pulse, err_count++, err_sticky=1, → ERROR.
  - ERROR: invalid → stay; valid → ACQUIRE, lock_cnt=1.
- prev: loaded with the decoded index on every valid code, in every state.
- err_count: 4-bit, saturates at 15.
- Pulses: step_pulse and err_pulse are one-cycle, registered, coincident with the index update.
- clear (uio_in[0]=1):
  - Synchronous; step_count, err_count and err_sticky go to 0 next cycle.
  - Clear wins over a simultaneous increment; pulses and FSM transitions still occur that cycle.
- ena=0: FSM, prev, lock_cnt, counters and index hold; pulses forced 0; clear ignored.
- Mode bit uio_in[1] selects the uo_out mux combinationally (no latency).
- For N<8, index is zero-extended into its 4-bit field.

Decomposition:
- Package johnson_pkg holds:
  - state enum (ACQUIRE, LOCKED, ERROR, 2-bit);
  - uio_out bit-position constants;
  - UIO_OE constant;
  - function next_idx(idx, N) for the mod-2N increment.
- Sub-module johnson_code_decode (purely combinational): code[N-1:0] → valid, index[IW-1:0].
- Top holds the synchronizer, FSM and counters.

Test Plan:
- Reset, then drive codes 0x00,0x01,0x03,0x07 (each 4 clk) → locked=1 once index=3 is seen; step_count=0 until the next +1, state=01.
- Locked; drive the full 16-code cycle twice including 0x80→0x00 → step_count=32, err_count=0, index walks 0..15 then wraps to 0.
- Locked at 0x07; drive 0x3F (skip 3→6) → err_pulse one cycle, err_count=1, err_sticky=1, state=00, locked=0.
- Locked; drive 0x05 (invalid) → state=10, err_count+1; then 0x0F,0x1F,0x3F,0x7F → ACQUIRE then LOCKED again.
- Force 20 errors → err_count saturates at 15. Pulse uio_in[0] coincident with an error → err_count=0, err_sticky=0 next cycle.
- ena=0 while ui_in steps → uo_out frozen, no pulses. Assert rst_n=0 mid-LOCKED → all outputs 0 immediately; uio_oe=0xFC throughout.
